fdc_seek_read: RTL and testbench

FDC_SEEK_READ -- requirements
Module: fdc_seek_read

---
 rtl/fdc_seek_read.sv | 211 +++++++++++++++++++++
 tb/tb_fdc_seek_read.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_seek_read.sv
// Floppy controller seek/read sequencer: spins up the drive, steps the head to the
// target track, then optionally finds the target sector and strobes its data bytes.
module fdc_seek_read #(
    parameter int STEP_PULSE_CLKS = 16,
    parameter int SETTLE_MIN_CLKS = 4,
    parameter int MAX_STEPS       = 250,
    parameter int REVS_TIMEOUT    = 5,
    parameter int MOTOR_HOLD_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_seek_only,
    input  logic [7:0]  target_track,
    input  logic [4:0]  target_sector,
    output logic        select,
    output logic        motor_on,
    output logic        step_in,
    output logic        step_out,
    input  logic [7:0]  track,
    input  logic [4:0]  sector,
    input  logic        sector_hdr,
    input  logic        sector_data,
    input  logic        dclk_en,
    input  logic        ready,
    input  logic        index,
    output logic        busy,
    output logic        done,
    output logic        rnf,
    output logic        seek_err,
    output logic        byte_stb,
    output logic [10:0] byte_idx
);
    // state   | meaning
    // IDLE    | waiting for cmd_start, motor hold timer running
    // SPINUP  | drive selected, waiting for ready
    // COMPARE | head vs target decision
    // STEP    | one step line held high
    // SETTLE  | minimum settle time, then wait for ready
    // SEARCH  | looking for the target sector header
    // XFER    | strobing data bytes of the matched sector
    // FINISH  | one-cycle done pulse
    localparam int TMR_MAX = (STEP_PULSE_CLKS > SETTLE_MIN_CLKS) ? STEP_PULSE_CLKS : SETTLE_MIN_CLKS;
    localparam int TW = $clog2(TMR_MAX + 1);
    localparam int HW = $clog2(MOTOR_HOLD_CLKS + 1);
    localparam int RW = $clog2(REVS_TIMEOUT + 1);
    localparam logic [7:0] MAX_STEPS_L = 8'(MAX_STEPS);

    typedef enum logic [2:0] {IDLE, SPINUP, COMPARE, STEP, SETTLE, SEARCH, XFER, FINISH} state_t;

    state_t        state_q, state_d;
    logic          seek_only_q, seek_only_d;
    logic [7:0]    tgt_track_q, tgt_track_d;
    logic [4:0]    tgt_sector_q, tgt_sector_d;
    logic [7:0]    step_cnt_q, step_cnt_d;
    logic          dir_out_q, dir_out_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rev_q, rev_d;
    logic [10:0]   idx_q, idx_d;
    logic          got_stb_q, got_stb_d;
    logic          rnf_q, rnf_d;
    logic          seek_err_q, seek_err_d;
    logic          index_prev_q, data_prev_q, hdr_prev_q;

    logic index_fall, data_fall, hdr_rise, stb;

    always_comb begin
        index_fall = index_prev_q & ~index;
        data_fall  = data_prev_q & ~sector_data;
        hdr_rise   = ~hdr_prev_q & sector_hdr;
        stb        = (state_q == XFER) && dclk_en && sector_data;

        state_d      = state_q;
        seek_only_d  = seek_only_q;
        tgt_track_d  = tgt_track_q;
        tgt_sector_d = tgt_sector_q;
        step_cnt_d   = step_cnt_q;
        dir_out_d    = dir_out_q;
        tmr_d        = tmr_q;
        hold_d       = hold_q;
        rev_d        = rev_q;
        idx_d        = idx_q;
        got_stb_d    = got_stb_q;
        rnf_d        = rnf_q;
        seek_err_d   = seek_err_q;

        case (state_q)
            IDLE: begin
                if (hold_q != '0) hold_d = hold_q - HW'(1);
                if (cmd_start) begin
                    seek_only_d  = cmd_seek_only;
                    tgt_track_d  = target_track;
                    tgt_sector_d = target_sector;
                    rnf_d        = 1'b0;
                    seek_err_d   = 1'b0;
                    step_cnt_d   = '0;
                    hold_d       = '0;
                    state_d      = SPINUP;
                end
            end
            SPINUP: if (ready) state_d = COMPARE;
            COMPARE: begin
                if (track == tgt_track_q) begin
                    if (seek_only_q) state_d = FINISH;
                    else begin
                        state_d = SEARCH;
                        rev_d   = '0;
                    end
                end else if (step_cnt_q == MAX_STEPS_L) begin
                    seek_err_d = 1'b1;
                    state_d    = FINISH;
                end else begin
                    if (step_cnt_q != 8'hFF) step_cnt_d = step_cnt_q + 8'd1;
                    dir_out_d = (tgt_track_q > track);
                    tmr_d     = TW'(STEP_PULSE_CLKS - 1);
                    state_d   = STEP;
                end
            end
            STEP: begin
                if (tmr_q == '0) begin
                    tmr_d   = TW'(SETTLE_MIN_CLKS);
                    state_d = SETTLE;
                end else tmr_d = tmr_q - TW'(1);
            end
            SETTLE: begin
                if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
                else if (ready) state_d = COMPARE;
            end
            SEARCH: begin
                if (sector_hdr && sector == tgt_sector_q) begin
                    idx_d     = '0;
                    got_stb_d = 1'b0;
                    state_d   = XFER;
                end else if (index_fall) begin
                    if (rev_q == RW'(REVS_TIMEOUT - 1)) begin
                        rnf_d   = 1'b1;
                        state_d = FINISH;
                    end else rev_d = rev_q + RW'(1);
                end
            end
            XFER: begin
                if (stb) begin
                    idx_d     = idx_q + 11'd1;
                    got_stb_d = 1'b1;
                end
                // A fresh header before any data means the matched sector had no data field.
                if (got_stb_q && data_fall) state_d = FINISH;
                else if (!got_stb_q && hdr_rise) begin
                    rnf_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                hold_d  = HW'(MOTOR_HOLD_CLKS);
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            seek_only_q  <= 1'b0;
            tgt_track_q  <= '0;
            tgt_sector_q <= '0;
            step_cnt_q   <= '0;
            dir_out_q    <= 1'b0;
            tmr_q        <= '0;
            hold_q       <= '0;
            rev_q        <= '0;
            idx_q        <= '0;
            got_stb_q    <= 1'b0;
            rnf_q        <= 1'b0;
            seek_err_q   <= 1'b0;
            index_prev_q <= 1'b0;
            data_prev_q  <= 1'b0;
            hdr_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            seek_only_q  <= seek_only_d;
            tgt_track_q  <= tgt_track_d;
            tgt_sector_q <= tgt_sector_d;
            step_cnt_q   <= step_cnt_d;
            dir_out_q    <= dir_out_d;
            tmr_q        <= tmr_d;
            hold_q       <= hold_d;
            rev_q        <= rev_d;
            idx_q        <= idx_d;
            got_stb_q    <= got_stb_d;
            rnf_q        <= rnf_d;
            seek_err_q   <= seek_err_d;
            index_prev_q <= index;
            data_prev_q  <= sector_data;
            hdr_prev_q   <= sector_hdr;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE) && (state_q != FINISH);
        done     = (state_q == FINISH);
        step_out = (state_q == STEP) && dir_out_q;
        step_in  = (state_q == STEP) && !dir_out_q;
        motor_on = (state_q != IDLE) || (hold_q != '0);
        select   = motor_on;
        rnf      = rnf_q;
        seek_err = seek_err_q;
        byte_stb = stb;
        byte_idx = idx_q;
    end
endmodule

// File: tb/tb_fdc_seek_read.sv
// Directed bench for fdc_seek_read: a rotating-disk drive model plus a per-cycle
// monitor of pulse widths, byte sequence, done/busy and motor hold.
module tb_fdc_seek_read;
    localparam int STEP_CLKS = 16, SETTLE_CLKS = 4, MAXS = 250, REVS = 5, HOLD = 60;
    localparam int SECT_LEN = 272, SPT = 10, LEAD = 8, REV_LEN = LEAD + SPT * SECT_LEN;

    logic clk = 1'b0, reset = 1'b1, cmd_start = 1'b0, cmd_seek_only = 1'b0;
    logic [7:0] target_track = '0;
    logic [4:0] target_sector = '0;
    logic select, motor_on, step_in, step_out, busy, done, rnf, seek_err, byte_stb;
    logic [10:0] byte_idx;
    logic [7:0] track = '0;
    logic [4:0] sector = '0;
    logic sector_hdr = 1'b0, sector_data = 1'b0, dclk_en = 1'b0, ready = 1'b0, index = 1'b1;

    fdc_seek_read #(.STEP_PULSE_CLKS(STEP_CLKS), .SETTLE_MIN_CLKS(SETTLE_CLKS), .MAX_STEPS(MAXS),
                    .REVS_TIMEOUT(REVS), .MOTOR_HOLD_CLKS(HOLD)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_seek_only(cmd_seek_only),
        .target_track(target_track), .target_sector(target_sector), .select(select),
        .motor_on(motor_on), .step_in(step_in), .step_out(step_out), .track(track),
        .sector(sector), .sector_hdr(sector_hdr), .sector_data(sector_data), .dclk_en(dclk_en),
        .ready(ready), .index(index), .busy(busy), .done(done), .rnf(rnf), .seek_err(seek_err),
        .byte_stb(byte_stb), .byte_idx(byte_idx));

    always #5 clk = ~clk;

    // Drive model: head moves on each step-line rising edge, disk rotates one position per clock.
    int  pos = 0, head = 0, p_off = 0, p_sec = 0;
    bit  frozen = 1'b0, drive_ready = 1'b1;
    logic so_prev = 1'b0, si_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (step_out && !so_prev && !frozen && head < 255) head = head + 1;
        if (step_in && !si_prev && !frozen && head > 0) head = head - 1;
        so_prev = step_out;
        si_prev = step_in;
        pos = (pos + 1) % REV_LEN;
        index = (pos < 4) ? 1'b0 : 1'b1;
        if (pos >= LEAD) begin
            p_sec = (pos - LEAD) / SECT_LEN;
            p_off = (pos - LEAD) % SECT_LEN;
            sector      = 5'(p_sec);
            sector_hdr  = (p_off < 4);
            sector_data = (p_off >= 8 && p_off < 264);
            dclk_en     = (p_off >= 6 && p_off < 268);
        end else begin
            sector = '0; sector_hdr = 1'b0; sector_data = 1'b0; dclk_en = 1'b0;
        end
        ready = drive_ready;
        track = 8'(head);
    end

    int cmp_cnt = 0, err_cnt = 0;
    int n_so = 0, n_si = 0, n_stb = 0, n_done = 0, n_fall = 0, last_idx = -1;
    int run_len = 0, exp_idx = 0, hold_rem = 0, cur_tsec = 0;
    logic busy_prev = 1'b0, done_prev = 1'b0, step_prev = 1'b0, idx_prev_m = 1'b1;

    task automatic check_eq(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        bit exp_m;
        @(negedge clk);
        if (reset) begin
            hold_rem = 0; run_len = 0; busy_prev = 1'b0; done_prev = 1'b0; step_prev = 1'b0;
        end else begin
            check_eq("step_excl", step_in & step_out, 0);
            if (step_in || step_out) begin
                if (!step_prev) begin
                    if (step_out) n_so++;
                    else n_si++;
                end
                run_len++;
            end else if (step_prev) begin
                check_eq("step_width", run_len, STEP_CLKS);
                run_len = 0;
            end
            step_prev = step_in | step_out;
            if (busy && !busy_prev) exp_idx = 0;
            if (byte_stb) begin
                check_eq("byte_idx", byte_idx, exp_idx);
                check_eq("stb_src", (sector_data && sector == 5'(cur_tsec)) ? 1 : 0, 1);
                exp_idx++;
                n_stb++;
                last_idx = int'(byte_idx);
            end
            if (done) begin
                check_eq("done_busy", busy, 0);
                check_eq("done_single", done_prev, 0);
                n_done++;
                hold_rem = HOLD;
            end
            exp_m = busy || done || hold_rem > 0;
            check_eq("motor_on", motor_on, exp_m);
            check_eq("select", select, exp_m);
            if (!busy && !done && hold_rem > 0) hold_rem--;
            busy_prev = busy;
            done_prev = done;
        end
        if (idx_prev_m && !index) n_fall++;
        idx_prev_m = index;
    endtask

    task automatic start_cmd(input bit so, input int trk, input int sec);
        cmd_seek_only = so;
        target_track  = 8'(trk);
        target_sector = 5'(sec);
        cur_tsec      = sec;
        cmd_start     = 1'b1;
        tick();
        cmd_start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("done_timeout", 0, 1);
        tick();
    endtask

    int b_so, b_si, b_stb, b_done, b_fall;
    task automatic snap();
        b_so = n_so; b_si = n_si; b_stb = n_stb; b_done = n_done; b_fall = n_fall;
    endtask

    initial begin
        repeat (3) tick();
        check_eq("reset_ctl", {step_in, step_out, motor_on, select, busy, done}, 0);
        check_eq("reset_stat", {rnf, seek_err, byte_stb}, 0);
        check_eq("reset_idx", byte_idx, 0);
        reset = 1'b0;
        repeat (3) tick();

        // Seek 0 -> 3 with a delayed ready during spin-up
        snap();
        drive_ready = 1'b0;
        start_cmd(1'b1, 3, 0);
        repeat (20) tick();
        check_eq("spinup_busy", busy, 1);
        check_eq("spinup_nostep", n_so - b_so, 0);
        drive_ready = 1'b1;
        wait_done(2000);
        check_eq("seek3_out", n_so - b_so, 3);
        check_eq("seek3_in", n_si - b_si, 0);
        check_eq("seek3_err", seek_err, 0);
        check_eq("seek3_track", track, 3);

        snap();
        start_cmd(1'b1, 10, 0);
        wait_done(2000);
        check_eq("seek10_out", n_so - b_so, 7);
        check_eq("seek10_track", track, 10);

        // Read on current track: full 256-byte sector
        snap();
        start_cmd(1'b0, 10, 4);
        wait_done(2 * REV_LEN);
        check_eq("read_steps", (n_so - b_so) + (n_si - b_si), 0);
        check_eq("read_nstb", n_stb - b_stb, 256);
        check_eq("read_last_idx", last_idx, 255);
        check_eq("read_rnf", rnf, 0);

        snap();
        start_cmd(1'b1, 7, 0);
        wait_done(2000);
        check_eq("seek7_in", n_si - b_si, 3);
        check_eq("seek7_out", n_so - b_so, 0);

        // Missing sector: record not found after the 5th index edge
        for (int i = 0; i < REV_LEN + 10 && pos != 100; i++) tick();
        snap();
        start_cmd(1'b0, 7, 20);
        wait_done(REVS * REV_LEN + 1000);
        check_eq("rnf_flag", rnf, 1);
        check_eq("rnf_edges", n_fall - b_fall, 5);
        check_eq("rnf_nostb", n_stb - b_stb, 0);
        repeat (5) tick();
        check_eq("rnf_hold", rnf, 1);

        // cmd_start during transfer is ignored
        snap();
        start_cmd(1'b0, 7, 4);
        for (int i = 0; i < 2 * REV_LEN && !byte_stb; i++) tick();
        check_eq("xfer_seen", byte_stb, 1);
        cmd_seek_only = 1'b1; target_track = 8'd2; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        wait_done(2 * REV_LEN);
        repeat (50) tick();
        check_eq("xfer_ndone", n_done - b_done, 1);
        check_eq("xfer_nstb", n_stb - b_stb, 256);
        check_eq("xfer_rnf", rnf, 0);
        check_eq("xfer_busy", busy, 0);
        check_eq("xfer_track", track, 7);

        snap();
        start_cmd(1'b1, 5, 0);
        wait_done(2000);
        check_eq("seek5_in", n_si - b_si, 2);

        // Frozen head: step budget exhausted
        frozen = 1'b1;
        snap();
        start_cmd(1'b1, 9, 0);
        wait_done(MAXS * 40);
        check_eq("frozen_out", n_so - b_so, MAXS);
        check_eq("frozen_err", seek_err, 1);
        check_eq("frozen_done", n_done - b_done, 1);
        repeat (5) tick();
        check_eq("frozen_err_hold", seek_err, 1);

        // Reset in the 8th cycle of a step pulse
        frozen = 1'b0;
        start_cmd(1'b1, 20, 0);
        for (int i = 0; i < 200 && !step_out; i++) tick();
        check_eq("abort_step_seen", step_out, 1);
        repeat (7) tick();
        check_eq("abort_pre", step_out, 1);
        reset = 1'b1;
        tick();
        check_eq("abort_step", step_out, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_outs", {step_in, motor_on, select, done, rnf, seek_err, byte_stb}, 0);
        reset = 1'b0;
        snap();
        repeat (200) tick();
        check_eq("abort_nostep", (n_so - b_so) + (n_si - b_si), 0);
        check_eq("abort_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
